hex_dumper: RTL

- Parametrised memory-to-UART hex dumper; successor of the fixed 16-words-per-line BRAM dumper.
- Reads an address range from a synchronous-read RAM port and emits ASCII lines through the existing serial_tx (sbyte/send/busy interface).
- Runs entirely on one clock (no derived-clock sequencing); supports start/abort, range wrap, configurable data width, words per line, and line ending.

---
 rtl/hex_dumper_pkg.sv | 42 ++++
 rtl/hex_dumper_char_emit.sv | 69 ++++++
 rtl/hex_dumper.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_dumper_pkg.sv
// Shared constants, state encodings and the nibble-to-ASCII helper for the
// hex dumper and its character emitter.
package hex_dumper_pkg;

   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_HASH   = 8'h23;
   localparam logic [7:0] CH_SPACE  = 8'h20;
   localparam logic [7:0] CH_CR     = 8'h0D;
   localparam logic [7:0] CH_LF     = 8'h0A;

   // Main sequencing FSM
   typedef enum logic [3:0] {
      StIdle,
      StHdr,
      StAddr,
      StSep,
      StRd,
      StRdWait,
      StData,
      StSpc,
      StEolCr,
      StEolLf,
      StDone
   } state_e;

   // Character handshake FSM
   typedef enum logic [2:0] {
      CeIdle,
      CeSend,
      CePulse,
      CeGuard,
      CeWait
   } ce_state_e;

   // Uppercase ASCII for one hex nibble
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      logic [7:0] wide;
      wide = {4'h0, nib};
      return (nib < 4'd10) ? (8'h30 + wide) : (8'h37 + wide);
   endfunction

endpackage

// File: rtl/hex_dumper_char_emit.sv
// Hands one character at a time to serial_tx: waits for the transmitter to be
// idle, pulses send for one cycle, lets one guard cycle pass so busy can rise,
// then holds until busy drops before acknowledging the requester.
module char_emit
   import hex_dumper_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       req,
   input  logic [7:0] char_in,
   output logic       ack,
   output logic [7:0] tx_byte,
   output logic       tx_send,
   input  logic       tx_busy
);

   ce_state_e  state_q, state_d;
   logic [7:0] byte_q, byte_d;
   logic       send_q, send_d;

   // State, held character and registered send pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CeIdle;
         byte_q  <= 8'h00;
         send_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
         send_q  <= send_d;
      end
   end

   // Handshake sequencing; the character is only reloaded from idle, so it
   // stays stable for the whole send/wait interval
   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      send_d  = 1'b0;
      ack     = 1'b0;
      unique case (state_q)
         CeIdle: begin
            if (req) begin
               byte_d  = char_in;
               state_d = CeSend;
            end
         end
         CeSend: begin
            if (!tx_busy) begin
               send_d  = 1'b1;
               state_d = CePulse;
            end
         end
         CePulse: state_d = CeGuard;
         CeGuard: state_d = CeWait;
         CeWait: begin
            if (!tx_busy) begin
               ack     = 1'b1;
               state_d = CeIdle;
            end
         end
         default: state_d = CeIdle;
      endcase
   end

   assign tx_byte = byte_q;
   assign tx_send = send_q;

endmodule

// File: rtl/hex_dumper.sv
// Memory-to-serial hex dumper: walks an inclusive, possibly wrapping address
// range, reads each word and prints "$AAA#DDDD DDDD ... \r\n" lines.
module hex_dumper
   import hex_dumper_pkg::*;
#(
   parameter int unsigned ADDR_W         = 10,
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned WORDS_PER_LINE = 16,
   parameter int unsigned RD_LATENCY     = 1,
   parameter int unsigned EOL_LF         = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] addr_from,
   input  logic [ADDR_W-1:0] addr_to,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   output logic [7:0]        tx_byte,
   output logic              tx_send,
   input  logic              tx_busy,
   output logic              busy,
   output logic              done
);

   localparam int unsigned NA         = (ADDR_W + 3) / 4;
   localparam int unsigned ND         = DATA_W / 4;
   localparam int unsigned ADDR_PAD_W = 4 * NA;
   localparam int unsigned NMAX       = (NA > ND) ? NA : ND;
   localparam int unsigned DIG_W      = $clog2(NMAX + 1);
   localparam int unsigned CNT_W      = $clog2(WORDS_PER_LINE + 1);

   state_e                state_q, state_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [ADDR_W-1:0]     to_q, to_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DIG_W-1:0]      dig_q, dig_d;
   logic [1:0]            lat_q, lat_d;
   logic [DATA_W-1:0]     sh_q, sh_d;
   logic [ADDR_PAD_W-1:0] ash_q, ash_d;
   logic                  fin_q, fin_d;
   logic                  abort_q, abort_d;

   logic                  ch_req;
   logic [7:0]            ch_char;
   logic                  ch_ack;
   state_e                eol_exit;

   char_emit u_char_emit (
      .clk     (clk),
      .reset   (reset),
      .req     (ch_req),
      .char_in (ch_char),
      .ack     (ch_ack),
      .tx_byte (tx_byte),
      .tx_send (tx_send),
      .tx_busy (tx_busy)
   );

   // Sequencer state and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         addr_q  <= '0;
         to_q    <= '0;
         cnt_q   <= '0;
         dig_q   <= '0;
         lat_q   <= '0;
         sh_q    <= '0;
         ash_q   <= '0;
         fin_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         to_q    <= to_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
         lat_q   <= lat_d;
         sh_q    <= sh_d;
         ash_q   <= ash_d;
         fin_q   <= fin_d;
         abort_q <= abort_d;
      end
   end

   // Next-state sequencing; abort is only acted on when a character completes
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      to_d    = to_q;
      cnt_d   = cnt_q;
      dig_d   = dig_q;
      lat_d   = lat_q;
      sh_d    = sh_q;
      ash_d   = ash_q;
      fin_d   = fin_q;
      abort_d = abort_q;
      ch_req  = 1'b0;
      ch_char = 8'h00;

      // Where a finished line ending leads
      if (abort_q || abort) begin
         eol_exit = StIdle;
      end else if (fin_q) begin
         eol_exit = StDone;
      end else begin
         eol_exit = StHdr;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               addr_d  = addr_from;
               to_d    = addr_to;
               fin_d   = 1'b0;
               abort_d = 1'b0;
               state_d = StHdr;
            end
         end
         StHdr: begin
            ch_req  = 1'b1;
            ch_char = CH_DOLLAR;
            cnt_d   = '0;
            if (ch_ack) begin
               if (abort) begin
                  abort_d = 1'b1;
                  state_d = StEolCr;
               end else begin
                  ash_d   = ADDR_PAD_W'(addr_q);
                  dig_d   = DIG_W'(NA - 1);
                  state_d = StAddr;
               end
            end
         end
         StAddr: begin
            ch_req  = 1'b1;
            ch_char = hex_ascii(ash_q[ADDR_PAD_W-1 -: 4]);
            if (ch_ack) begin
               ash_d = ash_q << 4;
               if (abort) begin
                  abort_d = 1'b1;
                  state_d = StEolCr;
               end else if (dig_q == '0) begin
                  state_d = StSep;
               end else begin
                  dig_d = dig_q - 1'b1;
               end
            end
         end
         StSep: begin
            ch_req  = 1'b1;
            ch_char = CH_HASH;
            if (ch_ack) begin
               if (abort) begin
                  abort_d = 1'b1;
                  state_d = StEolCr;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StRd: begin
            lat_d   = 2'd1;
            state_d = StRdWait;
         end
         StRdWait: begin
            // Capture exactly RD_LATENCY cycles after the read strobe
            if (lat_q == 2'(RD_LATENCY)) begin
               sh_d    = mem_data;
               dig_d   = DIG_W'(ND - 1);
               state_d = StData;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         StData: begin
            ch_req  = 1'b1;
            ch_char = hex_ascii(sh_q[DATA_W-1 -: 4]);
            if (ch_ack) begin
               sh_d = sh_q << 4;
               if (abort) begin
                  abort_d = 1'b1;
                  state_d = StEolCr;
               end else if (dig_q == '0) begin
                  state_d = StSpc;
               end else begin
                  dig_d = dig_q - 1'b1;
               end
            end
         end
         StSpc: begin
            ch_req  = 1'b1;
            ch_char = CH_SPACE;
            if (ch_ack) begin
               addr_d = addr_q + 1'b1;
               cnt_d  = cnt_q + 1'b1;
               if (addr_q == to_q) begin
                  fin_d = 1'b1;
               end
               if (abort) begin
                  abort_d = 1'b1;
                  state_d = StEolCr;
               end else if ((addr_q == to_q) ||
                            (cnt_q == CNT_W'(WORDS_PER_LINE - 1))) begin
                  state_d = StEolCr;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StEolCr: begin
            ch_req  = 1'b1;
            ch_char = CH_CR;
            if (ch_ack) begin
               if (abort) begin
                  abort_d = 1'b1;
               end
               state_d = (EOL_LF != 0) ? StEolLf : eol_exit;
            end
         end
         StEolLf: begin
            ch_req  = 1'b1;
            ch_char = CH_LF;
            if (ch_ack) begin
               state_d = eol_exit;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign mem_addr = addr_q;
   assign mem_rd   = (state_q == StRd);
   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StDone);

endmodule
